// File: rtl/cpu_cycle_controller.sv
// Multi-cycle phase sequencer: FETCH -> EXEC1 -> EXEC2, with bus-wait and mul/div stalls,
// wait-state timeout detection and a HALTED park state.
module cpu_cycle_controller #(
  parameter int MAX_WAIT = 255,
  parameter int WAIT_W   = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       waitrequest,
  input  logic       pc_halt,
  input  logic       mem_access,
  input  logic       md_busy,
  output logic       fetch,
  output logic       exec1,
  output logic       exec2,
  output logic       instr_read,
  output logic       data_cycle,
  output logic       active,
  output logic       bus_error,
  output logic [2:0] state_dbg
);

  localparam logic [2:0] S_RESET  = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_EXEC1  = 3'd2;
  localparam logic [2:0] S_EXEC2  = 3'd3;
  localparam logic [2:0] S_HALTED = 3'd4;

  localparam logic [WAIT_W-1:0] MAX_CNT = WAIT_W'(MAX_WAIT);

  logic [2:0]        state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              mem_acc_q, mem_acc_d;
  logic              bus_error_q, bus_error_d;
  logic              wait_hit, timeout, stall;

  // Requests are decoded from the registered state, so an async reset kills them at once.
  assign instr_read = (state_q == S_FETCH) && !pc_halt;
  assign data_cycle = (state_q == S_EXEC2) && mem_acc_q;
  assign wait_hit   = (instr_read || data_cycle) && waitrequest;
  assign timeout    = wait_hit && (wait_cnt_q == MAX_CNT);
  assign stall      = md_busy || (mem_acc_q && waitrequest);

  assign active    = (state_q != S_HALTED);
  assign bus_error = bus_error_q;
  assign state_dbg = state_q;

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    mem_acc_d   = mem_acc_q;
    bus_error_d = bus_error_q;
    fetch       = 1'b0;
    exec1       = 1'b0;
    exec2       = 1'b0;

    case (state_q)
      S_RESET: state_d = S_FETCH;
      S_FETCH: begin
        if (pc_halt) begin
          state_d = S_HALTED;
        end else if (timeout) begin
          state_d     = S_HALTED;
          bus_error_d = 1'b1;
        end else if (!waitrequest) begin
          fetch   = 1'b1;
          state_d = S_EXEC1;
        end
      end
      S_EXEC1: begin
        exec1     = 1'b1;
        mem_acc_d = mem_access;
        state_d   = S_EXEC2;
      end
      S_EXEC2: begin
        if (timeout) begin
          state_d     = S_HALTED;
          bus_error_d = 1'b1;
        end else if (!stall) begin
          exec2     = 1'b1;
          mem_acc_d = 1'b0;
          state_d   = S_FETCH;
        end
      end
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_RESET;
    endcase
  end

  // Wait counter restarts on every phase change and saturates instead of wrapping.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (state_d != state_q) begin
      wait_cnt_d = '0;
    end else if (wait_hit && (wait_cnt_q != MAX_CNT)) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_RESET;
      wait_cnt_q  <= '0;
      mem_acc_q   <= 1'b0;
      bus_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_acc_q   <= mem_acc_d;
      bus_error_q <= bus_error_d;
    end
  end

endmodule

// File: tb/tb_cpu_cycle_controller.sv
// Scoreboard bench for cpu_cycle_controller: the driver queues the expected outputs of each
// cycle, a negedge monitor pops and compares them against the DUT.
module tb_cpu_cycle_controller;

  localparam int MAX_WAIT = 4;
  localparam int WAIT_W   = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       waitrequest = 1'b0;
  logic       pc_halt = 1'b0;
  logic       mem_access = 1'b0;
  logic       md_busy = 1'b0;
  logic       fetch, exec1, exec2, instr_read, data_cycle, active, bus_error;
  logic [2:0] state_dbg;

  cpu_cycle_controller #(.MAX_WAIT(MAX_WAIT), .WAIT_W(WAIT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .waitrequest(waitrequest),
    .pc_halt    (pc_halt),
    .mem_access (mem_access),
    .md_busy    (md_busy),
    .fetch      (fetch),
    .exec1      (exec1),
    .exec2      (exec2),
    .instr_read (instr_read),
    .data_cycle (data_cycle),
    .active     (active),
    .bus_error  (bus_error),
    .state_dbg  (state_dbg)
  );

  always #5 clk = ~clk;

  // Observation vector: state, fetch, exec1, exec2, instr_read, data_cycle, active, bus_error.
  typedef struct packed {
    logic [2:0] st;
    logic f, e1, e2, ir, dc, act, be;
  } obs_t;

  localparam obs_t E_RST  = 10'b000_0000010;
  localparam obs_t E_F    = 10'b001_1001010;
  localparam obs_t E_FW   = 10'b001_0001010;
  localparam obs_t E_FH   = 10'b001_0000010;
  localparam obs_t E_X1   = 10'b010_0100010;
  localparam obs_t E_X2   = 10'b011_0010010;
  localparam obs_t E_X2S  = 10'b011_0000010;
  localparam obs_t E_X2M  = 10'b011_0010110;
  localparam obs_t E_X2MS = 10'b011_0000110;
  localparam obs_t E_HALT = 10'b100_0000000;
  localparam obs_t E_HERR = 10'b100_0000001;

  obs_t sb_q[$];
  int   total = 0;
  int   bad = 0;
  int   n_popped = 0;

  function automatic obs_t observe();
    return {state_dbg, fetch, exec1, exec2, instr_read, data_cycle, active, bus_error};
  endfunction

  task automatic check(input string name, input obs_t act, input obs_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got st=%0d f/e1/e2/ir/dc/act/be=%b, want st=%0d f/e1/e2/ir/dc/act/be=%b",
               name, act.st, act[6:0], exp.st, exp[6:0]);
    end
  endtask

  // Drive one cycle of inputs just after the rising edge and queue that cycle's expected outputs.
  task automatic cyc(input bit r, input bit wr, input bit ph, input bit ma, input bit mb,
                     input obs_t e);
    @(posedge clk);
    #1;
    reset       = r;
    waitrequest = wr;
    pc_halt     = ph;
    mem_access  = ma;
    md_busy     = mb;
    sb_q.push_back(e);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        obs_t e;
        e = sb_q.pop_front();
        check($sformatf("cycle%0d", n_popped), observe(), e);
        n_popped++;
      end
    end
  end

  initial begin
    // Reset held, then released: one more RESET cycle before FETCH.
    cyc(1, 0, 0, 0, 0, E_RST);
    cyc(1, 0, 0, 0, 0, E_RST);
    cyc(0, 0, 0, 0, 0, E_RST);

    // Zero-wait steady state: two instructions, 3 cycles each.
    for (int i = 0; i < 2; i++) begin
      cyc(0, 0, 0, 0, 0, E_F);
      cyc(0, 0, 0, 0, 0, E_X1);
      cyc(0, 0, 0, 0, 0, E_X2);
    end

    // Four fetch wait states (exactly MAX_WAIT, so no error), fetch pulses on the 5th cycle.
    for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0, 0, E_FW);
    cyc(0, 0, 0, 0, 0, E_F);
    cyc(0, 0, 0, 1, 0, E_X1);

    // Load/store in EXEC2: md_busy for 2 cycles, waitrequest for 3; completes when both clear.
    cyc(0, 1, 0, 0, 1, E_X2MS);
    cyc(0, 1, 0, 0, 1, E_X2MS);
    cyc(0, 1, 0, 0, 0, E_X2MS);
    cyc(0, 0, 0, 0, 0, E_X2M);

    // EXEC1 never stalls; waitrequest is ignored in EXEC2 without a load/store.
    cyc(0, 0, 0, 0, 0, E_F);
    cyc(0, 1, 0, 0, 0, E_X1);
    cyc(0, 1, 0, 0, 0, E_X2);

    // Timeout: the 5th consecutive wait cycle raises bus_error and parks the core.
    for (int i = 0; i < 5; i++) cyc(0, 1, 0, 0, 0, E_FW);
    cyc(0, 0, 1, 1, 1, E_HERR);
    cyc(0, 1, 0, 0, 0, E_HERR);

    // Reset leaves HALTED and clears bus_error.
    cyc(1, 0, 0, 0, 0, E_RST);
    cyc(0, 0, 0, 0, 0, E_RST);

    // pc_halt on FETCH entry: no read, no fetch, HALTED is absorbing.
    cyc(0, 0, 1, 0, 0, E_FH);
    cyc(0, 1, 0, 1, 1, E_HALT);
    cyc(0, 0, 1, 0, 0, E_HALT);
    cyc(0, 0, 0, 0, 0, E_HALT);

    // Reach a stalled EXEC2, then reset asynchronously between clock edges.
    cyc(1, 0, 0, 0, 0, E_RST);
    cyc(0, 0, 0, 0, 0, E_RST);
    cyc(0, 0, 0, 0, 0, E_F);
    cyc(0, 0, 0, 1, 0, E_X1);
    cyc(0, 0, 0, 0, 1, E_X2MS);
    cyc(1, 0, 0, 0, 1, E_RST);
    #1;
    check("async_reset_no_edge", observe(), E_RST);
    cyc(0, 0, 0, 0, 0, E_RST);
    cyc(0, 0, 0, 0, 0, E_F);
    cyc(0, 0, 0, 0, 0, E_X1);

    // Bounded drain of the scoreboard.
    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
    #1;
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d entries left, want 0", sb_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cpu_cycle_controller.md
Name: cpu_cycle_controller

Overview:
- Multi-cycle sequencer for the MIPS core.
- Drives the one-hot phase strobes fetch/exec1/exec2 consumed by the program counter, register file and ALU.
- Stalls phases on memory-bus waitrequest and on a busy multiply/divide unit.
- Detects halt (PC at address 0) and bus timeouts, then parks the core in HALTED.

Parameters:
- MAX_WAIT, 255: consecutive waitrequest cycles tolerated in one phase before a bus error; must be ≥1.
- WAIT_W, 8: width of the wait counter; must satisfy 2^WAIT_W > MAX_WAIT.

Ports:
- clk  in  1  core clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- waitrequest  in  1  memory bus not ready; current transfer must be held
- pc_halt  in  1  PC address equals 0
- mem_access  in  1  decoder: current instruction is a load/store; sampled in EXEC1
- md_busy  in  1  multiply/divide unit still computing; holds EXEC2
- fetch  out  1  fetch-phase completion pulse (PC advances on it)
- exec1  out  1  exec1-phase strobe
- exec2  out  1  exec2-phase completion pulse (PC latches jump decision on it)
- instr_read  out  1  instruction-memory read request, held for the whole FETCH state
- data_cycle  out  1  data-memory transfer request, held for the whole EXEC2 state when a load/store is latched
- active  out  1  core running
- bus_error  out  1  sticky timeout flag
- state_dbg  out  3  encoded state for the debug bus

Behaviour:
- State encoding: RESET=0, FETCH=1, EXEC1=2, EXEC2=3, HALTED=4.
- Reset (async): state=RESET, wait_cnt=0, mem_acc_q=0, bus_error=0.
  - All strobes are 0 while reset is high and during RESET, so the PC's synchronous reset vector load is not disturbed.
  - active=1 in RESET.
- RESET -> FETCH unconditionally, one cycle after reset deasserts.
- FETCH:
  - pc_halt=1: instr_read=0, fetch=0, next state HALTED.
  - Otherwise: instr_read=1, fetch = !waitrequest (combinational).
  - waitrequest=0: next EXEC1. waitrequest=1: stay in FETCH.
  - fetch is high on exactly one cycle per instruction, so the PC increments exactly once.
- EXEC1:
  - exec1=1 for exactly one cycle; never stalls.
  - mem_acc_q <= mem_access.
  - Next state EXEC2.
- EXEC2:
  - data_cycle = mem_acc_q.
  - stall = md_busy | (mem_acc_q & waitrequest).
  - exec2 = !stall (combinational).
  - stall=0: next FETCH, mem_acc_q cleared. stall=1: stay in EXEC2.
  - waitrequest is ignored when mem_acc_q=0.
- Wait counter:
  - Increments on each cycle with instr_read&waitrequest or data_cycle&waitrequest.
  - Clears on any state change.
  - md_busy-only stall cycles do not count.
  - If waitrequest=1 while wait_cnt==MAX_WAIT: bus_error<=1, next HALTED, and fetch/exec2 stay 0 on that cycle.
  - wait_cnt never wraps.
- HALTED:
  - Absorbing until reset.
  - active=0 and all strobes/requests 0.
  - bus_error holds its value.
- Simultaneous md_busy and waitrequest in EXEC2: complete only when both are clear. Counter advances only on waitrequest cycles.
- Reset mid-phase: aborts immediately; no strobe emitted for the aborted phase.
- Steady-state latency: 3 cycles per instruction with zero wait states (FETCH, EXEC1, EXEC2).

Test Plan:
- Release reset, tie waitrequest=0, mem_access=0 → state_dbg sequence 0,1,2,3,1,2,3…; fetch/exec1/exec2 each pulse once per 3 cycles; active=1.
- waitrequest=1 for 4 cycles in FETCH → instr_read high for 5 cycles; fetch pulses once, on the 5th cycle; EXEC1 follows.
- mem_access=1 in EXEC1, md_busy=1 for 2 cycles plus overlapping waitrequest for 3 cycles → exec2 is low until both are low; single exec2 pulse; wait_cnt reached 3.
- pc_halt=1 on entry to FETCH → instr_read=0, fetch=0, HALTED next cycle, active=0; stays there despite toggling inputs.
- MAX_WAIT=4, waitrequest held high in FETCH → bus_error=1 and HALTED after the 5th wait cycle; no fetch pulse emitted.
- Assert reset asynchronously mid-EXEC2 with md_busy=1 → outputs clear without a clock edge; RESET then FETCH after release; bus_error=0.
